// File: rtl/rv_trace_pkg.sv
// Shared types for the retire-trace encoder: record layout, beat enum and sync byte.
// Record layout depends on RV_TRACE_STREAM_MEM_EN (memory address/data stored when defined).
package rv_trace_pkg;

    localparam logic [7:0] TRACE_SYNC = 8'hC5;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PC,
        INSTR,
        RDATA,
        MADDR,
        MDATA
    } trace_beat_e;

    // flags = {mem_write, mem_read, reg_write}
    typedef struct packed {
`ifdef RV_TRACE_STREAM_MEM_EN
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
`endif
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] reg_data;
        logic [2:0]  flags;
        logic [7:0]  seq;
        logic        drop;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    function automatic logic [31:0] hdr_word(input trace_rec_t rec);
        return {TRACE_SYNC, rec.seq, 12'b0, rec.drop, rec.flags};
    endfunction

endpackage

// File: rtl/rv_trace_fifo.sv
// Synchronous record FIFO; a push into a full FIFO is accepted when a pop completes the same cycle.
// Storage is not reset, only the pointers are.
module rv_trace_fifo
    import rv_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_push,
    input  logic [REC_W-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [REC_W-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             push_ok;
    logic             pop_ok;

    assign o_level = wr_ptr_q - rd_ptr_q;
    assign o_full  = (o_level == (AW + 1)'(DEPTH));
    assign o_empty = (o_level == '0);
    assign push_ok = i_push && (!o_full || i_pop);
    assign pop_ok  = i_pop && !o_empty;
    assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/rv_trace_stream.sv
// Retire-trace encoder: buffers one record per retired instruction and streams it as 32-bit beats.
// Define RV_TRACE_STREAM_MEM_EN to store and emit the MADDR/MDATA beats for loads and stores.
module rv_trace_stream
    import rv_trace_pkg::*;
#(
    parameter int IADDR_SPACE_BITS = 32,
    parameter int DEPTH            = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_retire_valid,
    input  logic [IADDR_SPACE_BITS-1:0]   i_pc,
    input  logic [31:0]                   i_instr,
    input  logic                          i_reg_write,
    input  logic [31:0]                   i_reg_data,
    input  logic                          i_mem_read,
    input  logic                          i_mem_write,
    input  logic [31:0]                   i_mem_addr,
    input  logic [31:0]                   i_mem_data,
    output logic [31:0]                   o_tdata,
    output logic                          o_tvalid,
    input  logic                          i_tready,
    output logic                          o_tlast,
    output logic                          o_overflow,
    output logic [$clog2(DEPTH):0]        o_level
);

    trace_beat_e      state_q;
    trace_beat_e      state_d;
    trace_rec_t       wr_rec;
    trace_rec_t       head;
    logic [REC_W-1:0] head_bits;
    logic [7:0]       seq_q;
    logic             drop_pending_q;
    logic             overflow_q;
    logic             full;
    logic             empty;
    logic             hs;
    logic             last_beat;
    logic             pop;
    logic             push_ok;
    logic             mem_any;
    logic             more_after_pop;

    assign o_tvalid       = (state_q != IDLE);
    assign o_overflow     = overflow_q;
    assign hs             = o_tvalid && i_tready;
    assign pop            = hs && last_beat;
    assign push_ok        = i_retire_valid && (!full || pop);
    assign head           = trace_rec_t'(head_bits);
    // After a pop the FIFO still holds a record if another was queued or one arrives now.
    assign more_after_pop = (o_level > ($clog2(DEPTH) + 1)'(1)) || i_retire_valid;

`ifdef RV_TRACE_STREAM_MEM_EN
    assign mem_any = head.flags[2] || head.flags[1];
`else
    logic unused_mem;
    assign mem_any    = 1'b0;
    assign unused_mem = ^{i_mem_addr, i_mem_data};
`endif

    always_comb begin
        wr_rec          = '0;
        wr_rec.pc       = 32'(i_pc);
        wr_rec.instr    = i_instr;
        wr_rec.reg_data = i_reg_data;
        wr_rec.flags    = {i_mem_write, i_mem_read, i_reg_write};
        wr_rec.seq      = seq_q;
        wr_rec.drop     = drop_pending_q;
`ifdef RV_TRACE_STREAM_MEM_EN
        wr_rec.mem_addr = i_mem_addr;
        wr_rec.mem_data = i_mem_data;
`endif
    end

    rv_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (i_retire_valid),
        .i_wdata   (wr_rec),
        .i_pop     (pop),
        .o_rdata   (head_bits),
        .o_full    (full),
        .o_empty   (empty),
        .o_level   (o_level)
    );

    // Every retire consumes a sequence number, even when its record is dropped.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            seq_q          <= '0;
            drop_pending_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else if (i_retire_valid) begin
            seq_q <= seq_q + 8'd1;
            if (push_ok) begin
                drop_pending_q <= 1'b0;
            end else begin
                drop_pending_q <= 1'b1;
                overflow_q     <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        last_beat = 1'b0;
        case (state_q)
            INSTR:   last_beat = !head.flags[0] && !mem_any;
            RDATA:   last_beat = !mem_any;
            MDATA:   last_beat = 1'b1;
            default: last_beat = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!empty || i_retire_valid) state_d = HDR;
            HDR:   if (hs) state_d = PC;
            PC:    if (hs) state_d = INSTR;
            INSTR: if (hs) begin
                if (last_beat)          state_d = more_after_pop ? HDR : IDLE;
                else if (head.flags[0]) state_d = RDATA;
                else                    state_d = MADDR;
            end
            RDATA: if (hs) begin
                if (last_beat) state_d = more_after_pop ? HDR : IDLE;
                else           state_d = MADDR;
            end
            MADDR: if (hs) state_d = MDATA;
            MDATA: if (hs) state_d = more_after_pop ? HDR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_tdata = '0;
        o_tlast = last_beat;
        case (state_q)
            HDR:   o_tdata = hdr_word(head);
            PC:    o_tdata = head.pc;
            INSTR: o_tdata = head.instr;
            RDATA: o_tdata = head.reg_data;
`ifdef RV_TRACE_STREAM_MEM_EN
            MADDR: o_tdata = head.mem_addr;
            MDATA: o_tdata = head.mem_data;
`endif
            default: o_tdata = '0;
        endcase
    end

endmodule

// File: tb/tb_rv_trace_stream.sv
// Directed bench for rv_trace_stream: reset, basic record, backpressure, overflow, memory beats,
// sequence wrap and asynchronous reset in the middle of a record.
module tb_rv_trace_stream;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_retire_valid = 1'b0;
    logic [31:0] i_pc = '0;
    logic [31:0] i_instr = '0;
    logic        i_reg_write = 1'b0;
    logic [31:0] i_reg_data = '0;
    logic        i_mem_read = 1'b0;
    logic        i_mem_write = 1'b0;
    logic [31:0] i_mem_addr = '0;
    logic [31:0] i_mem_data = '0;
    logic [31:0] o_tdata;
    logic        o_tvalid;
    logic        i_tready = 1'b0;
    logic        o_tlast;
    logic        o_overflow;
    logic [3:0]  o_level;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [31:0] q_data[$];
    logic        q_last[$];
    int          q_cyc[$];

    rv_trace_stream #(
        .IADDR_SPACE_BITS (32),
        .DEPTH            (8)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_retire_valid (i_retire_valid),
        .i_pc           (i_pc),
        .i_instr        (i_instr),
        .i_reg_write    (i_reg_write),
        .i_reg_data     (i_reg_data),
        .i_mem_read     (i_mem_read),
        .i_mem_write    (i_mem_write),
        .i_mem_addr     (i_mem_addr),
        .i_mem_data     (i_mem_data),
        .o_tdata        (o_tdata),
        .o_tvalid       (o_tvalid),
        .i_tready       (i_tready),
        .o_tlast        (o_tlast),
        .o_overflow     (o_overflow),
        .o_level        (o_level)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Inputs change 1ns after posedge, so the negedge view is what the next posedge handshakes.
    always @(negedge i_clk) begin
        if (i_reset_n && o_tvalid && i_tready) begin
            q_data.push_back(o_tdata);
            q_last.push_back(o_tlast);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic apply_reset();
        i_reset_n      = 1'b0;
        i_retire_valid = 1'b0;
        i_tready       = 1'b0;
        repeat (2) tick();
        i_reset_n = 1'b1;
        tick();
        clear_q();
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic rw,
                          input logic [31:0] rdata, input logic mr, input logic mw,
                          input logic [31:0] maddr, input logic [31:0] mdata);
        i_pc           = pc;
        i_instr        = instr;
        i_reg_write    = rw;
        i_reg_data     = rdata;
        i_mem_read     = mr;
        i_mem_write    = mw;
        i_mem_addr     = maddr;
        i_mem_data     = mdata;
        i_retire_valid = 1'b1;
        tick();
        i_retire_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        int b = 0;
        while (q_data.size() < n && b < budget) begin
            tick();
            b++;
        end
        ok = (q_data.size() >= n);
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (o_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b expected 0", o_tvalid);
        else n_pass++;
        n_checks++;
        if (o_tlast !== 1'b0) $display("FAIL reset_tlast: got %b expected 0", o_tlast);
        else n_pass++;
        n_checks++;
        if (o_tdata !== 32'h0) $display("FAIL reset_tdata: got %h expected 00000000", o_tdata);
        else n_pass++;
        n_checks++;
        if (o_overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", o_overflow);
        else n_pass++;
        n_checks++;
        if (o_level !== 4'd0) $display("FAIL reset_level: got %0d expected 0", o_level);
        else n_pass++;
        i_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] exp_d [4] = '{32'hC5000001, 32'h00000100, 32'h00500093, 32'h00000005};
        bit ok;
        apply_reset();
        i_tready = 1'b1;
        retire(32'h100, 32'h00500093, 1'b1, 32'd5, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== 32'hC5000001)
            $display("FAIL basic_latency: got %b/%h expected 1/c5000001", o_tvalid, o_tdata);
        else n_pass++;
        wait_beats(4, 50, ok);
        n_checks++;
        if (!ok) $display("FAIL basic_beats: got %0d beats expected 4", q_data.size());
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            if (ok) begin
                n_checks++;
                if (q_data[k] !== exp_d[k] || q_last[k] !== (k == 3))
                    $display("FAIL basic_beat[%0d]: got %h/%b expected %h/%b",
                             k, q_data[k], q_last[k], exp_d[k], (k == 3));
                else n_pass++;
            end
        end
        n_checks++;
        if (o_tvalid !== 1'b0 || o_level !== 4'd0)
            $display("FAIL basic_idle: got %b/%0d expected 0/0", o_tvalid, o_level);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [4] = '{32'hC5000001, 32'h00000100, 32'h00500093, 32'h00000005};
        int bad = 0;
        bit ok;
        apply_reset();
        retire(32'h100, 32'h00500093, 1'b1, 32'd5, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 10; c++) begin
            if (o_tvalid !== 1'b1 || o_tdata !== 32'hC5000001 || o_tlast !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        else n_pass++;
        i_tready = 1'b1;
        wait_beats(4, 50, ok);
        n_checks++;
        if (!ok) $display("FAIL bp_beats: got %0d beats expected 4", q_data.size());
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            if (ok) begin
                n_checks++;
                if (q_data[k] !== exp_d[k] || q_last[k] !== (k == 3))
                    $display("FAIL bp_beat[%0d]: got %h/%b expected %h/%b",
                             k, q_data[k], q_last[k], exp_d[k], (k == 3));
                else n_pass++;
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        apply_reset();
        for (int i = 0; i < 10; i++)
            retire(32'h200 + 32'(4 * i), 32'h00000013, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (o_level !== 4'd8) $display("FAIL ovf_level: got %0d expected 8", o_level);
        else n_pass++;
        n_checks++;
        if (o_overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", o_overflow);
        else n_pass++;
        i_tready = 1'b1;
        wait_beats(24, 100, ok);
        n_checks++;
        if (!ok) $display("FAIL ovf_drain: got %0d beats expected 24", q_data.size());
        else n_pass++;
        if (ok) begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (q_data[3 * k] !== (32'hC5000000 | (32'(k) << 16)))
                    $display("FAIL ovf_hdr[%0d]: got %h expected %h",
                             k, q_data[3 * k], 32'hC5000000 | (32'(k) << 16));
                else n_pass++;
            end
            n_checks++;
            if (q_data[22] !== 32'h0000021C) $display("FAIL ovf_pc7: got %h expected 0000021c", q_data[22]);
            else n_pass++;
            n_checks++;
            if (q_cyc[23] - q_cyc[0] != 23)
                $display("FAIL ovf_no_bubble: got %0d cycles expected 23", q_cyc[23] - q_cyc[0]);
            else n_pass++;
        end
        n_checks++;
        if (o_level !== 4'd0) $display("FAIL ovf_level_drained: got %0d expected 0", o_level);
        else n_pass++;
        clear_q();
        retire(32'h300, 32'h00000013, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_beats(3, 50, ok);
        n_checks++;
        if (!ok || q_data[0] !== 32'hC50A0008)
            $display("FAIL ovf_drop_hdr: got %h expected c50a0008", ok ? q_data[0] : 32'h0);
        else n_pass++;
        n_checks++;
        if (o_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", o_overflow);
        else n_pass++;
    endtask

    task automatic test_mem();
        logic [31:0] exp_d [6];
        int n_exp;
        bit ok;
        apply_reset();
        i_tready = 1'b1;
        retire(32'h104, 32'h00A12023, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF);
`ifdef RV_TRACE_STREAM_MEM_EN
        n_exp = 5;
        exp_d = '{32'hC5000004, 32'h104, 32'h00A12023, 32'h2000, 32'hDEADBEEF, 32'h0};
`else
        n_exp = 3;
        exp_d = '{32'hC5000004, 32'h104, 32'h00A12023, 32'h0, 32'h0, 32'h0};
`endif
        wait_beats(n_exp, 50, ok);
        repeat (3) tick();
        n_checks++;
        if (q_data.size() != n_exp) $display("FAIL sw_count: got %0d expected %0d", q_data.size(), n_exp);
        else n_pass++;
        for (int k = 0; k < n_exp; k++) begin
            if (ok) begin
                n_checks++;
                if (q_data[k] !== exp_d[k] || q_last[k] !== (k == n_exp - 1))
                    $display("FAIL sw_beat[%0d]: got %h/%b expected %h/%b",
                             k, q_data[k], q_last[k], exp_d[k], (k == n_exp - 1));
                else n_pass++;
            end
        end
        clear_q();
        retire(32'h108, 32'h00012283, 1'b1, 32'h12345678, 1'b1, 1'b0, 32'h3000, 32'h12345678);
`ifdef RV_TRACE_STREAM_MEM_EN
        n_exp = 6;
        exp_d = '{32'hC5010003, 32'h108, 32'h00012283, 32'h12345678, 32'h3000, 32'h12345678};
`else
        n_exp = 4;
        exp_d = '{32'hC5010003, 32'h108, 32'h00012283, 32'h12345678, 32'h0, 32'h0};
`endif
        wait_beats(n_exp, 50, ok);
        repeat (3) tick();
        n_checks++;
        if (q_data.size() != n_exp) $display("FAIL lw_count: got %0d expected %0d", q_data.size(), n_exp);
        else n_pass++;
        for (int k = 0; k < n_exp; k++) begin
            if (ok) begin
                n_checks++;
                if (q_data[k] !== exp_d[k] || q_last[k] !== (k == n_exp - 1))
                    $display("FAIL lw_beat[%0d]: got %h/%b expected %h/%b",
                             k, q_data[k], q_last[k], exp_d[k], (k == n_exp - 1));
                else n_pass++;
            end
        end
    endtask

    task automatic test_seq_wrap();
        int bad = 0;
        bit ok;
        apply_reset();
        i_tready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            retire(32'h400, 32'h00000013, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            repeat (3) tick();
        end
        wait_beats(771, 200, ok);
        n_checks++;
        if (!ok) $display("FAIL wrap_beats: got %0d expected 771", q_data.size());
        else n_pass++;
        if (ok) begin
            for (int i = 0; i < 257; i++)
                if (q_data[3 * i] !== (32'hC5000000 | (32'(i % 256) << 16))) bad++;
            n_checks++;
            if (bad != 0) $display("FAIL wrap_seq: got %0d bad headers expected 0", bad);
            else n_pass++;
            n_checks++;
            if (q_data[768] !== 32'hC5000000) $display("FAIL wrap_last_hdr: got %h expected c5000000", q_data[768]);
            else n_pass++;
        end
        n_checks++;
        if (o_overflow !== 1'b0) $display("FAIL wrap_overflow: got %b expected 0", o_overflow);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        retire(32'h500, 32'h00100093, 1'b1, 32'd1, 1'b0, 1'b0, 32'h0, 32'h0);
        retire(32'h504, 32'h00100113, 1'b1, 32'd1, 1'b0, 1'b0, 32'h0, 32'h0);
        i_tready = 1'b1;
        repeat (2) tick();
        i_tready = 1'b0;
        n_checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== 32'h00100093)
            $display("FAIL mid_instr_beat: got %b/%h expected 1/00100093", o_tvalid, o_tdata);
        else n_pass++;
        #2;
        i_reset_n = 1'b0;
        #1;
        n_checks++;
        if (o_tvalid !== 1'b0 || o_tdata !== 32'h0 || o_tlast !== 1'b0)
            $display("FAIL mid_async_out: got %b/%h/%b expected 0/00000000/0", o_tvalid, o_tdata, o_tlast);
        else n_pass++;
        n_checks++;
        if (o_level !== 4'd0) $display("FAIL mid_async_level: got %0d expected 0", o_level);
        else n_pass++;
        repeat (2) tick();
        i_reset_n = 1'b1;
        tick();
        clear_q();
        i_tready = 1'b1;
        retire(32'h600, 32'h00200093, 1'b1, 32'd2, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_beats(4, 50, ok);
        n_checks++;
        if (!ok || q_data[0] !== 32'hC5000001 || q_data[1] !== 32'h600 || q_last[3] !== 1'b1)
            $display("FAIL mid_after_reset: got %h expected c5000001", ok ? q_data[0] : 32'h0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_mem();
        test_seq_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
